// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, drives the instruction ROM, registers the
// IF/ID latch, and shares the single ROM read port with a debug read port.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DBG_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data
);

    localparam int unsigned WAIT_W = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DBG_MAX_WAIT - 1);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DEBUG
    } state_t;

    state_t            state;
    logic [31:0]       pc;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dbg_grant;

    // The ROM port is owned by the debug path only during the single DEBUG cycle
    assign rom_ce    = (state != ST_IDLE);
    assign rom_addr  = (state == ST_DEBUG) ? dbg_addr : pc;
    assign dbg_grant = dbg_req && (stall || (wait_cnt == WAIT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            wait_cnt <= '0;
            if_pc    <= '0;
            if_instr <= '0;
            if_valid <= 1'b0;
            dbg_ack  <= 1'b0;
            dbg_data <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (flush) begin
                        pc       <= new_pc & ALIGN_MASK;
                        if_valid <= 1'b0;
                    end else if (dbg_grant) begin
                        state    <= ST_DEBUG;
                        wait_cnt <= '0;
                    end else begin
                        // A pending request here implies stall=0, so it is aging toward a forced grant
                        wait_cnt <= dbg_req ? wait_cnt + WAIT_W'(1) : '0;
                        if (!stall) begin
                            if_instr <= rom_instr;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= branch_flag ? (branch_target & ALIGN_MASK) : pc + 32'd4;
                        end
                    end
                end
                ST_DEBUG: begin
                    dbg_data <= rom_instr;
                    dbg_ack  <= 1'b1;
                    state    <= ST_FETCH;
                    if (flush) begin
                        pc       <= new_pc & ALIGN_MASK;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl against a word-indexed ROM model (mem[i] = A500_0000 | i).
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_instr = 32'hA500_0000 | {2'b00, rom_addr[31:2]};

    if_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .DBG_MAX_WAIT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_instr    (rom_instr),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_ack      (dbg_ack),
        .dbg_data     (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] pc_e, input logic valid_e);
        check({tag, ".pc"}, if_pc, pc_e);
        check({tag, ".instr"}, if_instr, 32'hA500_0000 | {2'b00, pc_e[31:2]});
        check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid_e});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; new_pc = '0;
        branch_flag = 1'b0; branch_target = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state and first fetch latency
        do_reset();
        check("rst.if_pc", if_pc, 32'd0);
        check("rst.if_instr", if_instr, 32'd0);
        check("rst.valid", {31'd0, if_valid}, 32'd0);
        check("rst.ack", {31'd0, dbg_ack}, 32'd0);
        check("rst.dbg_data", dbg_data, 32'd0);
        check("rst.rom_ce", {31'd0, rom_ce}, 32'd0);
        tick();
        check("e0.valid", {31'd0, if_valid}, 32'd0);
        check("e0.rom_ce", {31'd0, rom_ce}, 32'd1);
        check("e0.rom_addr", rom_addr, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_if($sformatf("seq%0d", i), 32'(i * 4), 1'b1);
        end

        // Branch with delay slot, and a misaligned target
        do_reset();
        run(4);
        check("pre_br.rom_addr", rom_addr, 32'h0C);
        branch_flag = 1'b1; branch_target = 32'h50;
        tick();
        check_if("br.slot", 32'h0C, 1'b1);
        branch_flag = 1'b0;
        tick();
        check_if("br.tgt", 32'h50, 1'b1);
        branch_flag = 1'b1; branch_target = 32'h53;
        tick();
        check_if("br53.slot", 32'h54, 1'b1);
        branch_flag = 1'b0;
        tick();
        check_if("br53.tgt", 32'h50, 1'b1);

        // Stall freezes PC and IF/ID and masks branch_flag
        do_reset();
        run(5);
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_if($sformatf("stall%0d", i), 32'h0C, 1'b1);
            check($sformatf("stall%0d.addr", i), rom_addr, 32'h10);
        end
        stall = 1'b0; branch_flag = 1'b0;
        tick();
        check_if("stall.rel", 32'h10, 1'b1);

        // Debug read granted by stall; IF/ID untouched
        stall = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h20;
        tick();
        check("dbgs.addr", rom_addr, 32'h20);
        check("dbgs.ack0", {31'd0, dbg_ack}, 32'd0);
        tick();
        check("dbgs.ack", {31'd0, dbg_ack}, 32'd1);
        check("dbgs.data", dbg_data, 32'hA500_0008);
        check_if("dbgs.ifid", 32'h10, 1'b1);
        dbg_req = 1'b0; stall = 1'b0;
        tick();
        check("dbgs.ack_pulse", {31'd0, dbg_ack}, 32'd0);
        check_if("dbgs.resume", 32'h14, 1'b1);

        // Forced grant after DBG_MAX_WAIT fetch cycles, one bubble, no skip
        dbg_req = 1'b1; dbg_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_if($sformatf("fw%0d", i), 32'h18 + 32'(i * 4), 1'b1);
        end
        tick();
        check("fw.grant_addr", rom_addr, 32'h40);
        check_if("fw.grant_hold", 32'h20, 1'b1);
        tick();
        check("fw.ack", {31'd0, dbg_ack}, 32'd1);
        check("fw.data", dbg_data, 32'hA500_0010);
        check("fw.bubble", {31'd0, if_valid}, 32'd0);
        dbg_req = 1'b0;
        tick();
        check_if("fw.resume", 32'h24, 1'b1);

        // Flush during DEBUG: read still completes, fetch redirects
        stall = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h08;
        tick();
        flush = 1'b1; new_pc = 32'h183;
        tick();
        check("fl.ack", {31'd0, dbg_ack}, 32'd1);
        check("fl.data", dbg_data, 32'hA500_0002);
        check("fl.valid", {31'd0, if_valid}, 32'd0);
        flush = 1'b0; dbg_req = 1'b0; stall = 1'b0;
        tick();
        check_if("fl.tgt", 32'h180, 1'b1);

        // PC wrap at the top of the address space
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap.flush_valid", {31'd0, if_valid}, 32'd0);
        flush = 1'b0;
        tick();
        check_if("wrap.top", 32'hFFFF_FFFC, 1'b1);
        tick();
        check_if("wrap.zero", 32'h0, 1'b1);

        // Reset in the middle of DEBUG drops the read
        stall = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h30;
        tick();
        check("rd.addr", rom_addr, 32'h30);
        rst = 1'b1;
        tick();
        check("rd.ack", {31'd0, dbg_ack}, 32'd0);
        check("rd.data", dbg_data, 32'd0);
        check("rd.if_pc", if_pc, 32'd0);
        check("rd.if_instr", if_instr, 32'd0);
        check("rd.valid", {31'd0, if_valid}, 32'd0);
        check("rd.rom_ce", {31'd0, rom_ce}, 32'd0);
        rst = 1'b0; dbg_req = 1'b0; stall = 1'b0;
        tick();
        check("rd.after_ack", {31'd0, dbg_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
